oam_dma_arbiter: RTL

OAM_DMA_ARBITER -- requirements
Module: oam_dma_arbiter

---
 rtl/oam_dma_arbiter_pkg.sv | 21 ++
 rtl/oam_dma_arbiter.sv | 116 +++++++++++
 2 files changed

// File: rtl/oam_dma_arbiter_pkg.sv
// Shared constants, state encoding and source-page mapping for the OAM DMA arbiter.
package oam_dma_arbiter_pkg;

    localparam int unsigned DMA_LEN  = 160;
    localparam logic [15:0] OAM_BASE = 16'hFE00;
    localparam logic [15:0] DMA_REG  = 16'hFF46;
    localparam logic [7:0]  OPEN_BUS = 8'hFF;

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StRead,
        StWrite
    } dma_state_e;

    // Pages E0..FF alias the work RAM at C0..DF (echo RAM).
    function automatic logic [7:0] src_effective(input logic [7:0] src);
        return (src <= 8'hDF) ? src : src - 8'h20;
    endfunction

endpackage

// File: rtl/oam_dma_arbiter.sv
// OAM DMA engine sitting between the CPU decoder and the MMU; owns the MMU bus while a
// transfer is running and exposes the DMA start register.
module oam_dma_arbiter #(
    parameter int unsigned DMA_LEN  = oam_dma_arbiter_pkg::DMA_LEN,
    parameter logic [15:0] OAM_BASE = oam_dma_arbiter_pkg::OAM_BASE,
    parameter logic [15:0] DMA_REG  = oam_dma_arbiter_pkg::DMA_REG
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] A_up,
    input  logic [7:0]  Di_up,
    output logic [7:0]  Do_up,
    input  logic        wr_up,
    input  logic        rd_up,
    output logic [15:0] A_MMU,
    output logic [7:0]  Do_MMU,
    input  logic [7:0]  Di_MMU,
    output logic        wr_MMU,
    output logic        rd_MMU,
    output logic        dma_busy
);
    import oam_dma_arbiter_pkg::*;

    localparam logic [7:0] LastIdx = 8'(DMA_LEN - 1);

    dma_state_e state_q, state_d;
    logic [7:0] src_q, src_d;
    logic [7:0] idx_q, idx_d;
    logic [7:0] dl_q, dl_d;
    logic       reg_hit;
    logic       reg_wr;

    assign reg_hit = (A_up == DMA_REG);
    assign reg_wr  = reg_hit && wr_up;

    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        idx_d   = idx_q;
        dl_d    = dl_q;
        unique case (state_q)
            StIdle:  ;
            StStart: state_d = StRead;
            StRead: begin
                dl_d    = Di_MMU;
                state_d = StWrite;
            end
            StWrite: begin
                if (idx_q == LastIdx) begin
                    state_d = StIdle;
                end else begin
                    idx_d   = idx_q + 8'd1;
                    state_d = StRead;
                end
            end
            default: state_d = StIdle;
        endcase
        // A register write restarts from any state, including the final WRITE.
        if (reg_wr) begin
            src_d   = Di_up;
            idx_d   = 8'h00;
            state_d = StStart;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            src_q   <= 8'h00;
            idx_q   <= 8'h00;
            dl_q    <= 8'h00;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            idx_q   <= idx_d;
            dl_q    <= dl_d;
        end
    end

    always_comb begin
        A_MMU    = A_up;
        Do_MMU   = 8'h00;
        wr_MMU   = 1'b0;
        rd_MMU   = 1'b0;
        Do_up    = OPEN_BUS;
        dma_busy = 1'b1;
        unique case (state_q)
            StIdle: begin
                dma_busy = 1'b0;
                Do_up    = Di_MMU;
                if (!reg_hit) begin
                    wr_MMU = wr_up;
                    rd_MMU = rd_up;
                    if (wr_up || rd_up) begin
                        Do_MMU = Di_up;
                    end
                end
            end
            StStart: A_MMU = 16'h0000;
            StRead: begin
                A_MMU  = {src_effective(src_q), idx_q};
                rd_MMU = 1'b1;
            end
            StWrite: begin
                A_MMU  = OAM_BASE + {8'h00, idx_q};
                Do_MMU = dl_q;
                wr_MMU = 1'b1;
            end
            default: ;
        endcase
        if (reg_hit) begin
            Do_up = src_q;
        end
    end

endmodule
